// File: rtl/rr_mux_4_arbiter_pkg.sv
`default_nettype none
// ============================================================================
// Module      : rr_mux_4_arbiter_pkg
// Description : Shared constants, lock-state type and round-robin pick
//               helper for the rr_mux_4_arbiter block.
// Revision    : 1.0 - initial release
// ============================================================================
package rr_mux_4_arbiter_pkg;

  localparam int N_REQ = 4;
  localparam int SEL_W = 2;

  // Packet-lock state; only referenced when RR_ARB_LAST_EN is defined.
  typedef enum logic [0:0] {
    FREE   = 1'b0,
    LOCKED = 1'b1
  } lock_state_t;

  // Returns {found, idx}: the first valid requester searching from ptr+1
  // round to ptr itself. The slice of k wraps the search modulo N_REQ.
  function automatic logic [SEL_W:0] rr_pick(
    input logic [N_REQ-1:0] req_valid,
    input logic [SEL_W-1:0] ptr
  );
    logic [SEL_W:0]   res;
    logic [SEL_W-1:0] idx;
    res = '0;
    for (int k = 1; k <= N_REQ; k++) begin
      idx = ptr + k[SEL_W-1:0];
      if (!res[SEL_W] && req_valid[idx]) begin
        res = {1'b1, idx};
      end
    end
    return res;
  endfunction

endpackage
`default_nettype wire

// File: rtl/rr_mux_4_arbiter_mux_4_1.sv
`default_nettype none
// ============================================================================
// Module      : mux_4_1
// Description : Combinational 4:1 data multiplexer, W bits wide.
// Revision    : 1.0 - initial release
// ============================================================================
module mux_4_1 #(
  parameter int W = 4
) (
  input  logic [W-1:0] d0,
  input  logic [W-1:0] d1,
  input  logic [W-1:0] d2,
  input  logic [W-1:0] d3,
  input  logic [1:0]   sel,
  output logic [W-1:0] y
);

  // Steer the selected input to the output.
  always_comb begin
    y = d0;
    case (sel)
      2'd0:    y = d0;
      2'd1:    y = d1;
      2'd2:    y = d2;
      default: y = d3;
    endcase
  end

endmodule
`default_nettype wire

// File: rtl/rr_mux_4_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : rr_mux_4_arbiter
// Description : Registered round-robin arbiter sharing one W-bit output
//               channel between four valid/ready requesters. The winner's
//               data is steered through mux_4_1 into a one-entry output
//               register. Optional packet lock via macro RR_ARB_LAST_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module rr_mux_4_arbiter
  import rr_mux_4_arbiter_pkg::*;
#(
  parameter int W = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [N_REQ-1:0]   req_valid,
  input  logic [W-1:0]       req_data0,
  input  logic [W-1:0]       req_data1,
  input  logic [W-1:0]       req_data2,
  input  logic [W-1:0]       req_data3,
`ifdef RR_ARB_LAST_EN
  input  logic [N_REQ-1:0]   req_last,
  output logic               out_last,
`endif
  output logic [N_REQ-1:0]   req_ready,
  output logic               out_valid,
  output logic [W-1:0]       out_data,
  output logic [SEL_W-1:0]   out_sel,
  input  logic               out_ready
);

  logic               load;
  logic [N_REQ-1:0]   eligible;
  logic [SEL_W:0]     pick;
  logic               found;
  logic [SEL_W-1:0]   gidx;
  logic               grant;
  logic [SEL_W-1:0]   ptr;
  logic [W-1:0]       steered;

  // The output register can take a new beat when empty or being drained.
  assign load  = !out_valid || out_ready;
  assign found = pick[SEL_W];
  assign gidx  = pick[SEL_W-1:0];
  // Reset gates the grant so no requester is acknowledged during reset.
  assign grant = rst_n && load && found;

  // Round-robin winner among the requesters currently allowed to compete.
  always_comb begin
    pick = rr_pick(eligible, ptr);
  end

  // One-hot ready to the winning requester; no path from request data.
  always_comb begin
    req_ready = '0;
    if (grant) begin
      req_ready[gidx] = 1'b1;
    end
  end

  mux_4_1 #(
    .W (W)
  ) u_mux (
    .d0  (req_data0),
    .d1  (req_data1),
    .d2  (req_data2),
    .d3  (req_data3),
    .sel (gidx),
    .y   (steered)
  );

`ifdef RR_ARB_LAST_EN
  lock_state_t lock_state;
  lock_state_t lock_next;

  // Lock state register.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      lock_state <= FREE;
    end else begin
      lock_state <= lock_next;
    end
  end

  // Lock transitions: a non-last beat opens a packet, a last beat closes it.
  always_comb begin
    lock_next = lock_state;
    case (lock_state)
      FREE:    if (grant && !req_last[gidx]) lock_next = LOCKED;
      LOCKED:  if (grant &&  req_last[gidx]) lock_next = FREE;
      default: lock_next = FREE;
    endcase
  end

  // While locked only the owner competes; ptr always names the owner since
  // it holds the last granted index and only the owner is granted.
  always_comb begin
    eligible = req_valid;
    if (lock_state == LOCKED) begin
      eligible = req_valid & (N_REQ'(1) << ptr);
    end
  end

  // Last flag travels with its beat.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      out_last <= 1'b0;
    end else if (grant) begin
      out_last <= req_last[gidx];
    end
  end
`else
  // Without packet lock every requester competes on every beat.
  always_comb begin
    eligible = req_valid;
  end
`endif

  // Output register and priority pointer; everything holds under backpressure.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_sel   <= '0;
      ptr       <= SEL_W'(N_REQ - 1);
    end else if (load) begin
      if (grant) begin
        out_valid <= 1'b1;
        out_data  <= steered;
        out_sel   <= gidx;
        ptr       <= gidx;
      end else begin
        out_valid <= 1'b0;
      end
    end
  end

endmodule
`default_nettype wire
